// File: rtl/i2s_deserializer.sv
// i2s_deserializer
//   Captures a Philips I2S ADC stream (MSB first, one-bit delay after each
//   LR transition) into parallel left/right words. BCLK, LRCLK and data are
//   oversampled on i_clock, which must run at least 8x BCLK.
//
// Ports
//   i_clock            system clock
//   i_reset            asynchronous, active-high reset
//   i_codec_bit_clock  codec BCLK (async)
//   i_codec_lr_clock   codec LRCLK, low = left, high = right (async)
//   i_codec_adc_data   codec serial ADC data (async)
//   o_data_left        last complete left sample
//   o_data_right       last complete right sample
//   o_data_valid       one-cycle pulse when a new left/right pair is loaded
//   o_frame_error      one-cycle pulse when a channel is aborted by an early LR edge
//   o_error_count      (I2S_DESERIALIZER_ERROR_COUNT_EN only) saturating
//                      16-bit count of o_frame_error pulses
//
// Optional feature macro: I2S_DESERIALIZER_ERROR_COUNT_EN
module i2s_deserializer #(
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_codec_bit_clock,
    input  logic                  i_codec_lr_clock,
    input  logic                  i_codec_adc_data,
    output logic [DATA_WIDTH-1:0] o_data_left,
    output logic [DATA_WIDTH-1:0] o_data_right,
    output logic                  o_data_valid,
    output logic                  o_frame_error
`ifdef I2S_DESERIALIZER_ERROR_COUNT_EN
    ,
    output logic [15:0]           o_error_count
`endif
);

    localparam int unsigned      CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]    LAST_BIT = CW'(DATA_WIDTH - 1);

    // Bit positions inside the packed synchronizer vectors.
    localparam int unsigned SYNC_BCLK = 0;
    localparam int unsigned SYNC_LR   = 1;
    localparam int unsigned SYNC_DATA = 2;

    typedef enum logic [2:0] {
        WAIT_LR_FALLING,
        LEFT_SKIP,
        LEFT_CAPTURE,
        WAIT_LR_RISING,
        RIGHT_SKIP,
        RIGHT_CAPTURE
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            meta_q, meta_d;
    logic [2:0]            stable_q, stable_d;
    logic [2:0]            delay_q, delay_d;
    logic                  bclk_rise_q, bclk_rise_d;
    logic                  lr_rise_q, lr_rise_d;
    logic                  lr_fall_q, lr_fall_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] left_sr_q, left_sr_d;
    logic [DATA_WIDTH-1:0] right_sr_q, right_sr_d;
    logic                  commit_q, commit_d;
    logic [DATA_WIDTH-1:0] data_left_q, data_left_d;
    logic [DATA_WIDTH-1:0] data_right_q, data_right_d;
    logic                  valid_q, valid_d;
    logic                  frame_error_q, frame_error_d;
    logic                  sample_bit;

    // The delay stage of the data chain lines up with the cycle in which the
    // registered BCLK rise flag is high, i.e. the value seen at the BCLK edge.
    assign sample_bit = delay_q[SYNC_DATA];

    always_comb begin
        meta_d        = {i_codec_adc_data, i_codec_lr_clock, i_codec_bit_clock};
        stable_d      = meta_q;
        delay_d       = stable_q;
        bclk_rise_d   = stable_q[SYNC_BCLK] & ~delay_q[SYNC_BCLK];
        lr_rise_d     = stable_q[SYNC_LR] & ~delay_q[SYNC_LR];
        lr_fall_d     = ~stable_q[SYNC_LR] & delay_q[SYNC_LR];

        state_d       = state_q;
        cnt_d         = cnt_q;
        left_sr_d     = left_sr_q;
        right_sr_d    = right_sr_q;
        commit_d      = 1'b0;
        data_left_d   = data_left_q;
        data_right_d  = data_right_q;
        valid_d       = 1'b0;
        frame_error_d = 1'b0;

        if (commit_q) begin
            data_left_d  = left_sr_q;
            data_right_d = right_sr_q;
            valid_d      = 1'b1;
        end

        case (state_q)
            WAIT_LR_FALLING: begin
                if (lr_fall_q) begin
                    state_d = LEFT_SKIP;
                end
            end
            WAIT_LR_RISING: begin
                if (lr_rise_q) begin
                    state_d = RIGHT_SKIP;
                end
            end
            default: begin
                // An LR edge inside a channel wins over a coincident BCLK rise.
                if (lr_rise_q || lr_fall_q) begin
                    frame_error_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = lr_fall_q ? LEFT_SKIP : WAIT_LR_FALLING;
                end else if (bclk_rise_q) begin
                    case (state_q)
                        LEFT_SKIP: begin
                            cnt_d   = '0;
                            state_d = LEFT_CAPTURE;
                        end
                        RIGHT_SKIP: begin
                            cnt_d   = '0;
                            state_d = RIGHT_CAPTURE;
                        end
                        LEFT_CAPTURE: begin
                            left_sr_d = {left_sr_q[DATA_WIDTH-2:0], sample_bit};
                            if (cnt_q == LAST_BIT) begin
                                cnt_d   = '0;
                                state_d = WAIT_LR_RISING;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        RIGHT_CAPTURE: begin
                            right_sr_d = {right_sr_q[DATA_WIDTH-2:0], sample_bit};
                            if (cnt_q == LAST_BIT) begin
                                cnt_d    = '0;
                                commit_d = 1'b1;
                                state_d  = WAIT_LR_FALLING;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= WAIT_LR_FALLING;
            meta_q        <= '0;
            stable_q      <= '0;
            delay_q       <= '0;
            bclk_rise_q   <= 1'b0;
            lr_rise_q     <= 1'b0;
            lr_fall_q     <= 1'b0;
            cnt_q         <= '0;
            left_sr_q     <= '0;
            right_sr_q    <= '0;
            commit_q      <= 1'b0;
            data_left_q   <= '0;
            data_right_q  <= '0;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            meta_q        <= meta_d;
            stable_q      <= stable_d;
            delay_q       <= delay_d;
            bclk_rise_q   <= bclk_rise_d;
            lr_rise_q     <= lr_rise_d;
            lr_fall_q     <= lr_fall_d;
            cnt_q         <= cnt_d;
            left_sr_q     <= left_sr_d;
            right_sr_q    <= right_sr_d;
            commit_q      <= commit_d;
            data_left_q   <= data_left_d;
            data_right_q  <= data_right_d;
            valid_q       <= valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign o_data_left   = data_left_q;
    assign o_data_right  = data_right_q;
    assign o_data_valid  = valid_q;
    assign o_frame_error = frame_error_q;

`ifdef I2S_DESERIALIZER_ERROR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (frame_error_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign o_error_count = err_count_q;
`endif

endmodule

// File: tb/tb_i2s_deserializer.sv
module tb_i2s_deserializer;

    localparam int DW = 24;

    logic          clk;
    logic          rst;
    logic          bclk;
    logic          lrclk;
    logic          adc;
    logic [DW-1:0] o_data_left;
    logic [DW-1:0] o_data_right;
    logic          o_data_valid;
    logic          o_frame_error;
`ifdef I2S_DESERIALIZER_ERROR_COUNT_EN
    logic [15:0]   o_error_count;
`endif

    i2s_deserializer #(.DATA_WIDTH(DW)) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_codec_bit_clock (bclk),
        .i_codec_lr_clock  (lrclk),
        .i_codec_adc_data  (adc),
        .o_data_left       (o_data_left),
        .o_data_right      (o_data_right),
        .o_data_valid      (o_data_valid),
        .o_frame_error     (o_frame_error)
`ifdef I2S_DESERIALIZER_ERROR_COUNT_EN
        ,
        .o_error_count     (o_error_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Output monitor, sampled on the falling edge of the system clock.
    int            valid_cnt = 0;
    int            err_cnt   = 0;
    int            stable_viol = 0;
    logic [DW-1:0] prev_l = '0;
    logic [DW-1:0] prev_r = '0;

    always @(negedge clk) begin
        if (o_data_valid) valid_cnt++;
        if (o_frame_error) err_cnt++;
        if (!rst && !o_data_valid && ((o_data_left != prev_l) || (o_data_right != prev_r)))
            stable_viol++;
        prev_l = o_data_left;
        prev_r = o_data_right;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One I2S slot of nbclk BCLK periods (16 system clocks each). Data and LR
    // change on the BCLK falling edge; period 0 is the delay bit, periods
    // 1..DW carry the word MSB first, all other periods drive 1.
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int nbclk);
        for (int k = 0; k < nbclk; k++) begin
            bclk  = 1'b0;
            lrclk = lr;
            adc   = (k >= 1 && k <= DW) ? w[DW-k] : 1'b1;
            repeat (8) @(negedge clk);
            bclk = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nbclk);
        send_slot(1'b0, l, nbclk);
        send_slot(1'b1, r, nbclk);
    endtask

    typedef struct {
        logic [DW-1:0] left;
        logic [DW-1:0] right;
        int            nbclk;
        logic [DW-1:0] exp_left;
        logic [DW-1:0] exp_right;
    } vec_t;

    vec_t vecs[4];

    int v0;
    int e0;

    initial begin
        vecs[0] = '{24'hA5C3F0, 24'h5A0F3C, 32, 24'hA5C3F0, 24'h5A0F3C};
        vecs[1] = '{24'h800000, 24'h7FFFFF, 32, 24'h800000, 24'h7FFFFF};
        vecs[2] = '{24'h000001, 24'hFFFFFF, 25, 24'h000001, 24'hFFFFFF};
        vecs[3] = '{24'h123456, 24'hFEDCBA, 40, 24'h123456, 24'hFEDCBA};

        rst   = 1'b1;
        bclk  = 1'b0;
        lrclk = 1'b1;
        adc   = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_left",  32'(o_data_left),   32'h0);
        check("reset_right", 32'(o_data_right),  32'h0);
        check("reset_valid", 32'(o_data_valid),  32'h0);
        check("reset_error", 32'(o_frame_error), 32'h0);
        rst = 1'b0;

        // Start mid-way through a right slot: nothing may be captured from it.
        send_slot(1'b1, 24'h777777, 20);

        for (int i = 0; i < 4; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].left, vecs[i].right, vecs[i].nbclk);
            check($sformatf("vec%0d_valid_pulses", i), 32'(valid_cnt - v0), 32'd1);
            check($sformatf("vec%0d_error_pulses", i), 32'(err_cnt - e0),   32'd0);
            check($sformatf("vec%0d_left", i),  32'(o_data_left),  32'(vecs[i].exp_left));
            check($sformatf("vec%0d_right", i), 32'(o_data_right), 32'(vecs[i].exp_right));
        end
        check("outputs_stable_between_pulses", 32'(stable_viol), 32'd0);

        // Early LR rise after 10 left bits.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_slot(1'b0, 24'hFFFFFF, 11);
        send_slot(1'b1, 24'hABCDEF, 32);
        check("abort_error_pulses", 32'(err_cnt - e0),   32'd1);
        check("abort_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        check("abort_left_held",    32'(o_data_left),    32'h123456);
        check("abort_right_held",   32'(o_data_right),   32'hFEDCBA);

        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(24'h111111, 24'h222222, 32);
        check("post_abort_valid", 32'(valid_cnt - v0), 32'd1);
        check("post_abort_error", 32'(err_cnt - e0),   32'd0);
        check("post_abort_left",  32'(o_data_left),    32'h111111);
        check("post_abort_right", 32'(o_data_right),   32'h222222);

        // Reset in the middle of the right channel.
        v0 = valid_cnt;
        send_slot(1'b0, 24'h333333, 32);
        send_slot(1'b1, 24'h444444, 10);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_left",  32'(o_data_left),  32'h0);
        check("midreset_right", 32'(o_data_right), 32'h0);
        check("midreset_valid", 32'(o_data_valid), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_slot(1'b1, 24'h444444, 22);
        send_frame(24'h0F0F0F, 24'hF0F0F0, 32);
        check("after_reset_valid", 32'(valid_cnt - v0), 32'd1);
        check("after_reset_left",  32'(o_data_left),    32'h0F0F0F);
        check("after_reset_right", 32'(o_data_right),   32'hF0F0F0);

        // Three consecutive early LR edges.
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            send_slot(1'b0, 24'hC0FFEE, 11);
            send_slot(1'b1, 24'h000000, 5);
        end
        check("triple_abort_errors", 32'(err_cnt - e0),   32'd3);
        check("triple_abort_valid",  32'(valid_cnt - v0), 32'd0);
        check("triple_abort_left",   32'(o_data_left),    32'h0F0F0F);
`ifdef I2S_DESERIALIZER_ERROR_COUNT_EN
        check("error_count_3", 32'(o_error_count), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("error_count_reset", 32'(o_error_count), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_deserializer.md
Name: i2s_deserializer

Overview:
- Receive-side counterpart of the DAC serializer. Captures the codec ADC I2S stream (Philips I2S, MSB first, one-bit delay after each LR transition) into parallel left/right words.
- Runs on the system clock i_clock and oversamples the codec bit and LR clocks.
- Presents each captured stereo frame with a one-cycle valid pulse to the downstream audio datapath.

Parameters:
- DATA_WIDTH, 24, bits captured per channel (MSB first); slot bits beyond DATA_WIDTH are ignored.

Ports:
- i_clock  in  1  system clock; must be at least 8x the codec bit clock frequency.
- i_reset  in  1  asynchronous, active-high reset.
- i_codec_bit_clock  in  1  codec BCLK; asynchronous to i_clock.
- i_codec_lr_clock  in  1  codec LRCLK; low = left, high = right; asynchronous.
- i_codec_adc_data  in  1  codec serial ADC data; asynchronous.
- o_data_left  out  DATA_WIDTH  last complete left sample.
- o_data_right  out  DATA_WIDTH  last complete right sample.
- o_data_valid  out  1  one-cycle pulse; new left/right pair is on the outputs.
- o_frame_error  out  1  one-cycle pulse; channel aborted by an early LR edge.

Behaviour:
- Reset (async, active-high): all synchronizer flops, edge flags, shift registers and bit counter cleared; o_data_left = 0, o_data_right = 0, o_data_valid = 0, o_frame_error = 0; state = WAIT_LR_FALLING.
- Synchronizers:
  - BCLK, LRCLK and ADC data each pass through meta -> stable -> delay flops.
  - Registered rise/fall flags are computed from stable vs. delay for BCLK and LRCLK.
  - When the BCLK rise flag is high, the bit is sampled from the data delay stage. This matches the value present at the BCLK rising edge.
- A BCLK rising edge is a cycle with the BCLK rise flag high. LR edges are the registered LR rise/fall flags.
- States:
  - WAIT_LR_FALLING: wait for LR fall -> LEFT_SKIP.
  - LEFT_SKIP: the first BCLK rising edge is the I2S delay bit and is discarded; counter = 0 -> LEFT_CAPTURE.
  - LEFT_CAPTURE: on each BCLK rising edge, shift left register {reg[DATA_WIDTH-2:0], bit} and increment the counter. When the counter reaches DATA_WIDTH -> WAIT_LR_RISING, counter = 0.
  - WAIT_LR_RISING: remaining slot bits ignored; on LR rise -> RIGHT_SKIP.
  - RIGHT_SKIP / RIGHT_CAPTURE: same as the left channel, using the right register. On the DATA_WIDTH-th bit -> WAIT_LR_FALLING and commit.
- Commit, in the cycle after the last right bit is shifted in:
  - o_data_left and o_data_right are loaded from the shift registers.
  - o_data_valid = 1 for exactly one cycle.
  - Outputs hold until the next commit.
- Latency: valid pulse 2 i_clock cycles after the synchronized BCLK edge carrying the right LSB.
- Frame error:
  - An LR edge in LEFT_SKIP, LEFT_CAPTURE, RIGHT_SKIP or RIGHT_CAPTURE pulses o_frame_error for one cycle.
  - The partial frame is discarded: no valid, outputs unchanged, counter cleared.
  - Next state: LR fall -> LEFT_SKIP (new frame starts immediately); LR rise -> WAIT_LR_FALLING.
- Simultaneous LR edge and BCLK rise in the same cycle: the LR edge is processed and the BCLK rise is ignored.
- An LR rise in WAIT_LR_FALLING is ignored. Capture never starts mid-frame after reset; the first left channel is the first one following an LR fall.
- Continuous operation: back-to-back frames are captured with no gap; one valid pulse per complete frame.
- Slot length is free: any number of BCLKs per channel that is at least DATA_WIDTH+1 is accepted.

Optional Feature:
- Macro: I2S_DESERIALIZER_ERROR_COUNT_EN.
- Defined:
  - Adds output port o_error_count (16 bits), a saturating count of o_frame_error pulses.
  - Reset to 0; holds at 0xFFFF once reached.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Nominal capture: BCLK = i_clock/16, 32 BCLK per channel, left = 0xA5C3F0, right = 0x5A0F3C -> exactly one o_data_valid pulse; o_data_left = 0xA5C3F0, o_data_right = 0x5A0F3C; o_frame_error stays 0.
- Back-to-back frames: 0x800000/0x7FFFFF, then 0x000001/0xFFFFFF, then 0x123456/0xFEDCBA -> three valid pulses, each with the matching pair; outputs stable between pulses.
- Early LR rise after 10 left bits -> o_frame_error pulses once, no valid; the following frame 0x111111/0x222222 is captured correctly.
- Start after reset with LR high, mid-right slot -> no valid until a full frame after the first LR fall; first valid carries that frame's data.
- Reset asserted during RIGHT_CAPTURE -> all outputs 0 immediately (async), no valid; after release the next full frame 0x0F0F0F/0xF0F0F0 is captured.
- With I2S_DESERIALIZER_ERROR_COUNT_EN, inject 3 early LR edges -> o_error_count = 3; after reset o_error_count = 0.
